// File: rtl/cache_mem_arbiter_if.sv
// Bundles the icache, dcache and RAM port signals of the cache/memory arbiter.
// The slave modport is the arbiter's view; master is the environment (caches + RAM).
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache: data side wins by default, a
// starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 CLK,
    input logic                 RST,
    cache_mem_arbiter_if.slave  bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       dreq;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign dreq      = bus.dREN | bus.dWEN;

    // Outputs decode from the registered state, so an async reset drops the
    // RAM enables the moment it is asserted.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_d = 4'd0;
                end
                if (dreq && bus.iREN && starve_q == LIMIT) begin
                    state_d  = IGRANT;
                    starve_d = 4'd0;
                end else if (dreq) begin
                    state_d = DGRANT;
                    if (bus.iREN && starve_q < LIMIT) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.iREN) begin
                    state_d  = IGRANT;
                    starve_d = 4'd0;
                end
            end

            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                // Completion wins over a same-cycle withdrawal.
                if (bus.ramstate == RAM_ACCESS) begin
                    bus.iwait = 1'b0;
                    state_d   = IDLE;
                end else if (bus.ramstate == RAM_ERROR) begin
                    bus.err = 1'b1;
                    state_d = IDLE;
                end else if (!bus.iREN) begin
                    state_d = IDLE;
                end
            end

            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (bus.ramstate == RAM_ACCESS) begin
                    bus.dwait = 1'b0;
                    state_d   = IDLE;
                end else if (bus.ramstate == RAM_ERROR) begin
                    bus.err = 1'b1;
                    state_d = IDLE;
                end else if (!dreq) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1ns after CLK rise,
// outputs are sampled on the falling edge.
module tb_cache_mem_arbiter;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        @(negedge CLK);
        tests++; if (bus.iwait !== 1'b1) begin fails++; $display("FAIL reset_iwait got=%b exp=1", bus.iwait); end
        tests++; if (bus.dwait !== 1'b1) begin fails++; $display("FAIL reset_dwait got=%b exp=1", bus.dwait); end
        tests++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin fails++; $display("FAIL reset_en got=%b%b exp=00", bus.ramREN, bus.ramWEN); end
        tests++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin fails++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", bus.ramaddr, bus.ramstore); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_iread();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0040;
        bus.ramstate = BUSY;
        @(negedge CLK);
        tests++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin fails++; $display("FAIL iread_idle got ren=%b iwait=%b exp ren=0 iwait=1", bus.ramREN, bus.iwait); end
        next_cycle();
        @(negedge CLK);
        tests++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin fails++; $display("FAIL iread_grant_en got=%b%b exp=10", bus.ramREN, bus.ramWEN); end
        tests++; if (bus.ramaddr !== 32'h40) begin fails++; $display("FAIL iread_grant_addr got=%h exp=00000040", bus.ramaddr); end
        tests++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin fails++; $display("FAIL iread_busy_wait got i=%b d=%b exp i=1 d=1", bus.iwait, bus.dwait); end
        next_cycle();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hDEAD_BEEF;
        @(negedge CLK);
        tests++; if (bus.iwait !== 1'b0 || bus.dwait !== 1'b1) begin fails++; $display("FAIL iread_done_wait got i=%b d=%b exp i=0 d=1", bus.iwait, bus.dwait); end
        tests++; if (bus.iload !== 32'hDEAD_BEEF) begin fails++; $display("FAIL iread_iload got=%h exp=deadbeef", bus.iload); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        tests++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin fails++; $display("FAIL iread_after got iwait=%b ren=%b exp iwait=1 ren=0", bus.iwait, bus.ramREN); end
        next_cycle();
    endtask

    task automatic test_dwrite();
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h0000_0100;
        bus.dstore   = 32'h1234_5678;
        bus.ramstate = BUSY;
        @(negedge CLK);
        tests++; if (bus.ramWEN !== 1'b0) begin fails++; $display("FAIL dwrite_idle_wen got=%b exp=0", bus.ramWEN); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CLK);
            tests++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h1234_5678 || bus.dwait !== 1'b1)
                begin fails++; $display("FAIL dwrite_busy%0d got wen=%b ren=%b a=%h d=%h dwait=%b exp 1 0 00000100 12345678 1", i, bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait); end
        end
        next_cycle();
        bus.ramstate = ACCESS;
        @(negedge CLK);
        tests++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.dwait !== 1'b0 || bus.iwait !== 1'b1)
            begin fails++; $display("FAIL dwrite_access got wen=%b a=%h dwait=%b iwait=%b exp 1 00000100 0 1", bus.ramWEN, bus.ramaddr, bus.dwait, bus.iwait); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        tests++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin fails++; $display("FAIL dwrite_after got wen=%b ren=%b dwait=%b exp 0 0 1", bus.ramWEN, bus.ramREN, bus.dwait); end
        next_cycle();
    endtask

    task automatic test_starvation();
        byte exp_seq [6];
        byte got_seq [8];
        int  gcount;
        exp_seq = '{"D", "D", "D", "D", "I", "D"};
        gcount  = 0;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0040;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0200;
        bus.ramstate = ACCESS;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (bus.ramREN === 1'b1 || bus.ramWEN === 1'b1) begin
                if (gcount < 8) got_seq[gcount] = (bus.ramaddr === 32'h40) ? "I" : "D";
                if (bus.ramaddr === 32'h40) begin
                    tests++; if (bus.iwait !== 1'b0 || bus.dwait !== 1'b1) begin fails++; $display("FAIL starve_iwaits cyc%0d got i=%b d=%b exp i=0 d=1", c, bus.iwait, bus.dwait); end
                end else begin
                    tests++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin fails++; $display("FAIL starve_dwaits cyc%0d got i=%b d=%b exp i=1 d=0", c, bus.iwait, bus.dwait); end
                end
                gcount++;
            end
            next_cycle();
        end
        tests++; if (gcount !== 6) begin fails++; $display("FAIL starve_count got=%0d exp=6", gcount); end
        for (int g = 0; g < 6; g++) begin
            byte act;
            act = (g < gcount) ? got_seq[g] : "-";
            tests++; if (act !== exp_seq[g]) begin fails++; $display("FAIL starve_order%0d got=%c exp=%c", g, act, exp_seq[g]); end
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_rw_both();
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h0000_0300;
        bus.dstore   = 32'hCAFE_0001;
        bus.ramstate = ACCESS;
        next_cycle();
        @(negedge CLK);
        tests++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin fails++; $display("FAIL rw_both_en got wen=%b ren=%b exp 1 0", bus.ramWEN, bus.ramREN); end
        tests++; if (bus.dwait !== 1'b0 || bus.ramstore !== 32'hCAFE_0001) begin fails++; $display("FAIL rw_both_done got dwait=%b d=%h exp 0 cafe0001", bus.dwait, bus.ramstore); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_error();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0080;
        bus.ramstate = FREE;
        @(negedge CLK);
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_idle got=%b exp=0", bus.err); end
        next_cycle();
        bus.ramstate = ERROR;
        @(negedge CLK);
        tests++; if (bus.err !== 1'b1 || bus.iwait !== 1'b1 || bus.ramREN !== 1'b1) begin fails++; $display("FAIL err_pulse got err=%b iwait=%b ren=%b exp 1 1 1", bus.err, bus.iwait, bus.ramREN); end
        next_cycle();
        bus.ramstate = FREE;
        @(negedge CLK);
        tests++; if (bus.err !== 1'b0 || bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin fails++; $display("FAIL err_idle_after got err=%b ren=%b iwait=%b exp 0 0 1", bus.err, bus.ramREN, bus.iwait); end
        next_cycle();
        bus.ramstate = ACCESS;
        @(negedge CLK);
        tests++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h80 || bus.iwait !== 1'b0 || bus.err !== 1'b0)
            begin fails++; $display("FAIL err_regrant got ren=%b a=%h iwait=%b err=%b exp 1 00000080 0 0", bus.ramREN, bus.ramaddr, bus.iwait, bus.err); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_async_reset();
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h0000_0400;
        bus.dstore   = 32'h0BAD_F00D;
        bus.ramstate = BUSY;
        next_cycle();
        @(negedge CLK);
        tests++; if (bus.ramWEN !== 1'b1) begin fails++; $display("FAIL arst_pre_wen got=%b exp=1", bus.ramWEN); end
        #2;
        RST          = 1'b1;
        bus.ramstate = ACCESS;
        #1;
        tests++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin fails++; $display("FAIL arst_en got wen=%b ren=%b exp 0 0", bus.ramWEN, bus.ramREN); end
        tests++; if (bus.dwait !== 1'b1 || bus.iwait !== 1'b1) begin fails++; $display("FAIL arst_wait got d=%b i=%b exp 1 1", bus.dwait, bus.iwait); end
        next_cycle();
        bus.dWEN = 1'b0;
        @(negedge CLK);
        tests++; if (bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0) begin fails++; $display("FAIL arst_hold got dwait=%b wen=%b exp 1 0", bus.dwait, bus.ramWEN); end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        tests++; if (bus.dwait !== 1'b1 || bus.iwait !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0)
            begin fails++; $display("FAIL arst_release got d=%b i=%b wen=%b ren=%b exp 1 1 0 0", bus.dwait, bus.iwait, bus.ramWEN, bus.ramREN); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_iread();
        test_dwrite();
        test_starvation();
        test_rw_both();
        test_error();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the instruction cache and data cache onto the single shared RAM port.
- Sits between the icache/dcache miss/fill interfaces and the RAM.
- Grants one requester at a time and holds the grant until the RAM completes the access.
- Data side has default priority; a starvation counter guarantees instruction fetches make progress.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all load/store ports
STARVE_LIMIT, 4, consecutive data grants issued while iREN is pending before the instruction side is forcibly granted (legal range 1..15)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache address
iwait  out  1  1 = icache must keep waiting; 0 = iload valid this cycle
iload  out  DATA_W  instruction data to icache
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache address
dstore  in  DATA_W  dcache write data
dwait  out  1  1 = dcache must keep waiting; 0 = access complete this cycle
dload  out  DATA_W  data to dcache
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
err  out  1  one-cycle pulse on RAM ERROR during a grant

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- Reset: state=IDLE, starve_cnt=0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0. An RST assertion mid-transaction aborts it immediately; the RAM enables drop in the same cycle.
- Pass-through paths: iload=ramload and dload=ramload, combinational at all times. Consumers sample them only when their wait signal is 0.
- Registered FSM states: IDLE, IGRANT, DGRANT.
- IDLE:
  - All RAM enables are 0; iwait=1, dwait=1.
  - Arbitration each cycle: dreq = dREN|dWEN.
  - If dreq and iREN and starve_cnt==STARVE_LIMIT -> IGRANT.
  - Else if dreq -> DGRANT.
  - Else if iREN -> IGRANT.
  - Else stay in IDLE.
- IGRANT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - If ramstate==ACCESS: iwait=0 this cycle, then -> IDLE.
  - If ramstate==ERROR: err=1, iwait stays 1, -> IDLE.
  - If iREN drops before completion (request withdrawn): enables drop that same cycle, -> IDLE, no err.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0. Else ramREN=dREN. If both dREN and dWEN are high, the write wins.
  - Completion on ACCESS: dwait=0 for that cycle, -> IDLE.
  - ERROR and withdrawal (dREN=dWEN=0) behave as in IGRANT.
- Latency: a request seen in IDLE at cycle N is granted in cycle N+1. The earliest completion is N+1 if ramstate==ACCESS in that cycle. Back-to-back transactions always pass through one IDLE cycle.
- Wait signals: the non-granted requester's wait is 1 throughout. wait=0 lasts exactly one cycle per completed access.
- Starvation counter (starve_cnt, 4 bits):
  - Increments, saturating at STARVE_LIMIT, on each IDLE->DGRANT transition taken while iREN=1.
  - Clears to 0 on IDLE->IGRANT.
  - Clears to 0 in any IDLE cycle where iREN=0.
- Simultaneous events: a new request arriving during a grant is ignored until IDLE. A request that drops in the same cycle as ACCESS still counts as complete (wait=0 driven).
- Addresses and data are passed unmodified; no alignment checks are performed.

Test Plan:
- Reset, then lone iREN, iaddr=0x0000_0040, ramstate=ACCESS with ramload=0xDEAD_BEEF one cycle after the grant -> ramREN=1, ramaddr=0x40 in the grant cycle; iwait=0 and iload=0xDEADBEEF for exactly one cycle; dwait=1 throughout.
- dWEN, daddr=0x100, dstore=0x1234_5678, ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 held 4 cycles with address and data stable; dwait=0 only in the ACCESS cycle; then IDLE with enables 0.
- iREN and dREN asserted in the same IDLE cycle, STARVE_LIMIT=4, RAM always ACCESS -> grant order D,D,D,D,I while dREN remains asserted; starve_cnt returns to 0 after the I grant.
- dREN=dWEN=1 together -> ramWEN=1, ramREN=0.
- ramstate=ERROR during IGRANT -> err pulses for 1 cycle, iwait stays 1, FSM returns to IDLE and re-grants on the next cycle while iREN is still high.
- RST asserted asynchronously mid-DGRANT (between clock edges) -> ramWEN/ramREN go to 0 immediately, dwait=1, state IDLE after release; no spurious wait=0 on either side.
